axi4lite_master: RTL and testbench
==================================

Name: axi4lite_master

Overview:
- Synthesizable single-outstanding AXI4-Lite initiator. Converts a simple valid/ready command/response interface into AXI4-Lite read and write transactions.
- Drives the same axi4lite_if signal set that axi4lite_slave responds to. Used for RTL-only loopback against axi4lite_slave and as the bus front end for on-chip control logic.
- No WSTRB or PROT: full-word writes only, matching the existing interface.

Parameters:
ADDR_W, 32, address width of cmd_addr / AW_ADDR / AR_ADDR
DATA_W, 32, data width of cmd_wdata / W_DATA / R_DATA / rsp_rdata
TIMEOUT_CYCLES, 256, max cycles waiting in a response phase; 0 disables timeout

Ports:
aclk  in  1  clock, all logic on rising edge
aresetn  in  1  synchronous reset, active-low
cmd_valid  in  1  command request
cmd_ready  out  1  block idle, command accepted when cmd_valid && cmd_ready
cmd_write  in  1  1 = write, 0 = read
cmd_addr  in  ADDR_W  transaction address
cmd_wdata  in  DATA_W  write data (ignored for reads)
rsp_valid  out  1  response available
rsp_ready  in  1  response consumer ready
rsp_write  out  1  response belongs to a write
rsp_rdata  out  DATA_W  read data (0 for writes and timeouts)
rsp_resp  out  2  AXI resp: 00 OKAY, 10 SLVERR, 11 DECERR (timeout)
rsp_timeout  out  1  response produced by timeout, not by the slave
AW_VALID / AW_READY / AW_ADDR  out / in / out  1/1/ADDR_W  write address channel
W_VALID / W_READY / W_DATA  out / in / out  1/1/DATA_W  write data channel
B_VALID / B_READY / B_RESP  in / out / in  1/1/2  write response channel
AR_VALID / AR_READY / AR_ADDR  out / in / out  1/1/ADDR_W  read address channel
R_VALID / R_READY / R_DATA / R_RESP  in / out / in / in  1/1/DATA_W/2  read data channel

Behaviour:
- Interface rule: one clock aclk; aresetn is synchronous, active-low.
- Reset: state=IDLE. All VALID/READY outputs 0. Address/data outputs 0. rsp_* 0. Timeout counter 0. Reset mid-transaction aborts immediately; no response is produced. The slave is expected to be reset by the same aresetn.
- States: IDLE, WR_REQ, WR_RESP, RD_REQ, RD_DATA, RSP.
- IDLE: cmd_ready=1. On accept, register addr/wdata/write. Next cycle enter WR_REQ with AW_VALID=W_VALID=1, or RD_REQ with AR_VALID=1. Valid rises 1 cycle after accept.
- WR_REQ: AW and W are independent. Each VALID drops the cycle after its own handshake and is never withdrawn before it. Leave WR_REQ when both handshakes are done, including the same-cycle case. Order AW-first, W-first and simultaneous must all work.
- WR_RESP: B_READY=1. On B_VALID, capture B_RESP, drop B_READY, go to RSP.
- RD_REQ: AR_VALID held until AR_READY, then RD_DATA.
- RD_DATA: R_READY=1. On R_VALID, capture R_DATA/R_RESP, go to RSP.
- Ready outputs (B_READY/R_READY) are asserted only in WR_RESP/RD_DATA. No combinational path from any input to any output.
- RSP: rsp_valid=1 and rsp_* held stable until rsp_ready. Return to IDLE the cycle after that handshake; cmd_ready rises then. Throughput is 1 transaction per ≥4 cycles with a zero-wait slave.
- Timeout:
  - Counter clears on entering WR_RESP/RD_DATA and increments each cycle there.
  - Reaching TIMEOUT_CYCLES without handshake forces RSP with rsp_resp=11, rsp_timeout=1, rsp_rdata=0, and drops B_READY/R_READY.
  - Request phases never time out, because AXI forbids VALID withdrawal.
  - A late B/R after timeout is not consumed; the bus is treated as hung and recovery is by reset only.
- Responses from the slave pass through unmodified (OKAY/SLVERR/DECERR). rsp_timeout=0 in that case.

Decomposition:
- axi4lite_pkg: resp_t enum (OKAY=00, EXOKAY=01, SLVERR=10, DECERR=11), master state_t enum, default ADDR_W/DATA_W localparams.
- Single module; no sub-module is natural. Timeout counter is inline, width $clog2(TIMEOUT_CYCLES+1).
- A wrapper variant with an axi_if.master modport port is allowed later; the flat ports above are the contract.

Test Plan:
- Write 0x0000_0004 ← 0x1234_5678, slave zero-wait → AW_VALID/W_VALID rise 1 cycle after accept; B OKAY; rsp_valid with rsp_write=1, rsp_resp=00, rsp_timeout=0.
- Read 0x0000_0004 after above → AR_ADDR=0x4; rsp_rdata=0x1234_5678, rsp_resp=00, rsp_write=0.
- Write with AW_READY delayed 3 cycles and W_READY immediate, then the reverse, then simultaneous → each VALID drops exactly the cycle after its own handshake; exactly one B consumed; rsp_resp=00 each time.
- rsp_ready held low 5 cycles after rsp_valid → rsp_* stable all 5 cycles; cmd_ready=0 until the cycle after the handshake; a new cmd then accepted.
- TIMEOUT_CYCLES=16, read with slave never asserting R_VALID → after 16 cycles in RD_DATA: R_READY=0, rsp_resp=11, rsp_timeout=1, rsp_rdata=0.
- aresetn=0 for 1 cycle while in WR_REQ with AW accepted and W pending → next cycle all outputs 0, state IDLE, no rsp_valid; a subsequent read of 0x8 completes normally.

Source files
------------

// File: rtl/axi4lite_pkg.sv
// -----------------------------------------------------------------------------
// axi4lite_pkg
// Shared types and defaults for the AXI4-Lite initiator:
//   - resp_t     : AXI response encoding (OKAY / EXOKAY / SLVERR / DECERR)
//   - state_t    : initiator FSM states
//   - AXI_ADDR_W / AXI_DATA_W : default bus widths
//   - cnt_width()  : width of a counter that must hold 0..limit (never 0 bits)
// -----------------------------------------------------------------------------
package axi4lite_pkg;

    localparam int AXI_ADDR_W = 32;
    localparam int AXI_DATA_W = 32;

    typedef enum logic [1:0] {
        RESP_OKAY   = 2'b00,
        RESP_EXOKAY = 2'b01,
        RESP_SLVERR = 2'b10,
        RESP_DECERR = 2'b11
    } resp_t;

    typedef enum logic [2:0] {
        ST_IDLE    = 3'd0,
        ST_WR_REQ  = 3'd1,
        ST_WR_RESP = 3'd2,
        ST_RD_REQ  = 3'd3,
        ST_RD_DATA = 3'd4,
        ST_RSP     = 3'd5
    } state_t;

    // A disabled timeout (limit 0) still needs a 1-bit counter to stay legal.
    function automatic int cnt_width(input int limit);
        if (limit > 0) begin
            return $clog2(limit + 1);
        end else begin
            return 1;
        end
    endfunction

endpackage

// File: rtl/axi4lite_master.sv
// -----------------------------------------------------------------------------
// axi4lite_master
// Single-outstanding AXI4-Lite initiator. A command (cmd_*) is accepted in
// IDLE, turned into one AXI4-Lite read or write, and the outcome is returned
// on rsp_*. Every output is driven straight from a flop.
//
// Ports:
//   aclk, aresetn            clock, synchronous active-low reset
//   cmd_valid/ready/write/addr/wdata   command request side
//   rsp_valid/ready/write/rdata/resp/timeout   response side
//   AW_*, W_*, B_*           AXI write address / data / response channels
//   AR_*, R_*                AXI read address / data channels
// -----------------------------------------------------------------------------
module axi4lite_master
    import axi4lite_pkg::*;
#(
    parameter int ADDR_W         = AXI_ADDR_W,
    parameter int DATA_W         = AXI_DATA_W,
    parameter int TIMEOUT_CYCLES = 256
) (
    input  logic              aclk,
    input  logic              aresetn,
    input  logic              cmd_valid,
    output logic              cmd_ready,
    input  logic              cmd_write,
    input  logic [ADDR_W-1:0] cmd_addr,
    input  logic [DATA_W-1:0] cmd_wdata,
    output logic              rsp_valid,
    input  logic              rsp_ready,
    output logic              rsp_write,
    output logic [DATA_W-1:0] rsp_rdata,
    output logic [1:0]        rsp_resp,
    output logic              rsp_timeout,
    output logic              AW_VALID,
    input  logic              AW_READY,
    output logic [ADDR_W-1:0] AW_ADDR,
    output logic              W_VALID,
    input  logic              W_READY,
    output logic [DATA_W-1:0] W_DATA,
    input  logic              B_VALID,
    output logic              B_READY,
    input  logic [1:0]        B_RESP,
    output logic              AR_VALID,
    input  logic              AR_READY,
    output logic [ADDR_W-1:0] AR_ADDR,
    input  logic              R_VALID,
    output logic              R_READY,
    input  logic [DATA_W-1:0] R_DATA,
    input  logic [1:0]        R_RESP
);

    localparam int              CNT_W   = cnt_width(TIMEOUT_CYCLES);
    localparam bit              TO_EN   = (TIMEOUT_CYCLES > 0);
    // Last counter value seen while waiting; the timeout fires on that cycle,
    // so the ready output is high for exactly TIMEOUT_CYCLES cycles.
    localparam logic [CNT_W-1:0] TO_LAST = CNT_W'((TIMEOUT_CYCLES > 0) ? (TIMEOUT_CYCLES - 1) : 0);

    state_t              r_state, w_state_nxt;
    logic                r_cmd_ready, w_cmd_ready_nxt;
    logic [ADDR_W-1:0]   r_addr, w_addr_nxt;
    logic [DATA_W-1:0]   r_wdata, w_wdata_nxt;
    logic                r_write, w_write_nxt;
    logic                r_aw_valid, w_aw_valid_nxt;
    logic                r_w_valid, w_w_valid_nxt;
    logic                r_b_ready, w_b_ready_nxt;
    logic                r_ar_valid, w_ar_valid_nxt;
    logic                r_r_ready, w_r_ready_nxt;
    logic                r_rsp_valid, w_rsp_valid_nxt;
    logic                r_rsp_write, w_rsp_write_nxt;
    logic [DATA_W-1:0]   r_rsp_rdata, w_rsp_rdata_nxt;
    logic [1:0]          r_rsp_resp, w_rsp_resp_nxt;
    logic                r_rsp_timeout, w_rsp_timeout_nxt;
    logic [CNT_W-1:0]    r_cnt, w_cnt_nxt;

    logic                w_aw_hs, w_w_hs, w_to_hit;

    assign w_aw_hs  = r_aw_valid && AW_READY;
    assign w_w_hs   = r_w_valid && W_READY;
    assign w_to_hit = TO_EN && (r_cnt == TO_LAST);

    // Next-state and next-output decode; every register holds by default.
    always_comb begin
        w_state_nxt       = r_state;
        w_cmd_ready_nxt   = r_cmd_ready;
        w_addr_nxt        = r_addr;
        w_wdata_nxt       = r_wdata;
        w_write_nxt       = r_write;
        w_aw_valid_nxt    = r_aw_valid;
        w_w_valid_nxt     = r_w_valid;
        w_b_ready_nxt     = r_b_ready;
        w_ar_valid_nxt    = r_ar_valid;
        w_r_ready_nxt     = r_r_ready;
        w_rsp_valid_nxt   = r_rsp_valid;
        w_rsp_write_nxt   = r_rsp_write;
        w_rsp_rdata_nxt   = r_rsp_rdata;
        w_rsp_resp_nxt    = r_rsp_resp;
        w_rsp_timeout_nxt = r_rsp_timeout;
        w_cnt_nxt         = r_cnt;

        case (r_state)
            ST_IDLE: begin
                w_cmd_ready_nxt = 1'b1;
                if (cmd_valid && r_cmd_ready) begin
                    w_cmd_ready_nxt = 1'b0;
                    w_addr_nxt      = cmd_addr;
                    w_write_nxt     = cmd_write;
                    if (cmd_write) begin
                        w_wdata_nxt    = cmd_wdata;
                        w_aw_valid_nxt = 1'b1;
                        w_w_valid_nxt  = 1'b1;
                        w_state_nxt    = ST_WR_REQ;
                    end else begin
                        w_ar_valid_nxt = 1'b1;
                        w_state_nxt    = ST_RD_REQ;
                    end
                end else begin
                    w_state_nxt = ST_IDLE;
                end
            end
            ST_WR_REQ: begin
                // A channel whose VALID is already low has completed earlier.
                if (w_aw_hs) begin
                    w_aw_valid_nxt = 1'b0;
                end else begin
                    w_aw_valid_nxt = r_aw_valid;
                end
                if (w_w_hs) begin
                    w_w_valid_nxt = 1'b0;
                end else begin
                    w_w_valid_nxt = r_w_valid;
                end
                if ((w_aw_hs || !r_aw_valid) && (w_w_hs || !r_w_valid)) begin
                    w_b_ready_nxt = 1'b1;
                    w_cnt_nxt     = '0;
                    w_state_nxt   = ST_WR_RESP;
                end else begin
                    w_state_nxt = ST_WR_REQ;
                end
            end
            ST_WR_RESP: begin
                if (B_VALID && r_b_ready) begin
                    w_b_ready_nxt     = 1'b0;
                    w_rsp_valid_nxt   = 1'b1;
                    w_rsp_write_nxt   = 1'b1;
                    w_rsp_rdata_nxt   = '0;
                    w_rsp_resp_nxt    = B_RESP;
                    w_rsp_timeout_nxt = 1'b0;
                    w_state_nxt       = ST_RSP;
                end else if (w_to_hit) begin
                    w_b_ready_nxt     = 1'b0;
                    w_rsp_valid_nxt   = 1'b1;
                    w_rsp_write_nxt   = 1'b1;
                    w_rsp_rdata_nxt   = '0;
                    w_rsp_resp_nxt    = RESP_DECERR;
                    w_rsp_timeout_nxt = 1'b1;
                    w_state_nxt       = ST_RSP;
                end else if (TO_EN) begin
                    w_cnt_nxt = r_cnt + CNT_W'(1);
                end else begin
                    w_cnt_nxt = r_cnt;
                end
            end
            ST_RD_REQ: begin
                if (r_ar_valid && AR_READY) begin
                    w_ar_valid_nxt = 1'b0;
                    w_r_ready_nxt  = 1'b1;
                    w_cnt_nxt      = '0;
                    w_state_nxt    = ST_RD_DATA;
                end else begin
                    w_state_nxt = ST_RD_REQ;
                end
            end
            ST_RD_DATA: begin
                if (R_VALID && r_r_ready) begin
                    w_r_ready_nxt     = 1'b0;
                    w_rsp_valid_nxt   = 1'b1;
                    w_rsp_write_nxt   = 1'b0;
                    w_rsp_rdata_nxt   = R_DATA;
                    w_rsp_resp_nxt    = R_RESP;
                    w_rsp_timeout_nxt = 1'b0;
                    w_state_nxt       = ST_RSP;
                end else if (w_to_hit) begin
                    w_r_ready_nxt     = 1'b0;
                    w_rsp_valid_nxt   = 1'b1;
                    w_rsp_write_nxt   = 1'b0;
                    w_rsp_rdata_nxt   = '0;
                    w_rsp_resp_nxt    = RESP_DECERR;
                    w_rsp_timeout_nxt = 1'b1;
                    w_state_nxt       = ST_RSP;
                end else if (TO_EN) begin
                    w_cnt_nxt = r_cnt + CNT_W'(1);
                end else begin
                    w_cnt_nxt = r_cnt;
                end
            end
            ST_RSP: begin
                if (rsp_ready) begin
                    w_rsp_valid_nxt = 1'b0;
                    w_cmd_ready_nxt = 1'b1;
                    w_state_nxt     = ST_IDLE;
                end else begin
                    w_state_nxt = ST_RSP;
                end
            end
            default: begin
                w_state_nxt = ST_IDLE;
            end
        endcase
    end

    // FSM state register.
    always_ff @(posedge aclk) begin
        if (!aresetn) begin
            r_state <= ST_IDLE;
        end else begin
            r_state <= w_state_nxt;
        end
    end

    // Datapath and output registers; reset aborts any transaction in flight.
    always_ff @(posedge aclk) begin
        if (!aresetn) begin
            r_cmd_ready   <= 1'b0;
            r_addr        <= '0;
            r_wdata       <= '0;
            r_write       <= 1'b0;
            r_aw_valid    <= 1'b0;
            r_w_valid     <= 1'b0;
            r_b_ready     <= 1'b0;
            r_ar_valid    <= 1'b0;
            r_r_ready     <= 1'b0;
            r_rsp_valid   <= 1'b0;
            r_rsp_write   <= 1'b0;
            r_rsp_rdata   <= '0;
            r_rsp_resp    <= 2'b00;
            r_rsp_timeout <= 1'b0;
            r_cnt         <= '0;
        end else begin
            r_cmd_ready   <= w_cmd_ready_nxt;
            r_addr        <= w_addr_nxt;
            r_wdata       <= w_wdata_nxt;
            r_write       <= w_write_nxt;
            r_aw_valid    <= w_aw_valid_nxt;
            r_w_valid     <= w_w_valid_nxt;
            r_b_ready     <= w_b_ready_nxt;
            r_ar_valid    <= w_ar_valid_nxt;
            r_r_ready     <= w_r_ready_nxt;
            r_rsp_valid   <= w_rsp_valid_nxt;
            r_rsp_write   <= w_rsp_write_nxt;
            r_rsp_rdata   <= w_rsp_rdata_nxt;
            r_rsp_resp    <= w_rsp_resp_nxt;
            r_rsp_timeout <= w_rsp_timeout_nxt;
            r_cnt         <= w_cnt_nxt;
        end
    end

    assign cmd_ready   = r_cmd_ready;
    assign rsp_valid   = r_rsp_valid;
    assign rsp_write   = r_rsp_write;
    assign rsp_rdata   = r_rsp_rdata;
    assign rsp_resp    = r_rsp_resp;
    assign rsp_timeout = r_rsp_timeout;
    assign AW_VALID    = r_aw_valid;
    assign AW_ADDR     = r_addr;
    assign W_VALID     = r_w_valid;
    assign W_DATA      = r_wdata;
    assign B_READY     = r_b_ready;
    assign AR_VALID    = r_ar_valid;
    assign AR_ADDR     = r_addr;
    assign R_READY     = r_r_ready;

endmodule

// File: tb/tb_axi4lite_master.sv
// -----------------------------------------------------------------------------
// tb_axi4lite_master
// Directed bench for axi4lite_master (TIMEOUT_CYCLES = 16). A table of
// transactions with hand-computed expectations drives a behavioural slave
// with per-vector channel delays; reset abort is a hand-written sequence.
// -----------------------------------------------------------------------------
module tb_axi4lite_master;

    logic        aclk;
    logic        aresetn;
    logic        cmd_valid, cmd_ready, cmd_write;
    logic [31:0] cmd_addr, cmd_wdata;
    logic        rsp_valid, rsp_ready, rsp_write, rsp_timeout;
    logic [31:0] rsp_rdata;
    logic [1:0]  rsp_resp;
    logic        AW_VALID, AW_READY, W_VALID, W_READY;
    logic [31:0] AW_ADDR, W_DATA;
    logic        B_VALID, B_READY;
    logic [1:0]  B_RESP;
    logic        AR_VALID, AR_READY;
    logic [31:0] AR_ADDR;
    logic        R_VALID, R_READY;
    logic [31:0] R_DATA;
    logic [1:0]  R_RESP;

    int total = 0;
    int bad   = 0;

    logic [31:0] mem [16];

    typedef struct {
        logic        wr;
        logic [31:0] addr;
        logic [31:0] wdata;
        int          a_dly;   // AW_READY / AR_READY delay
        int          w_dly;   // W_READY delay
        int          r_dly;   // B_VALID / R_VALID delay, -1 = never
        logic [1:0]  sresp;   // response code the slave returns
        int          hold;    // cycles rsp_ready is held low
        logic [1:0]  e_resp;
        logic [31:0] e_rdata;
        logic        e_to;
    } vec_t;

    vec_t vecs [8];

    axi4lite_master #(
        .ADDR_W(32), .DATA_W(32), .TIMEOUT_CYCLES(16)
    ) dut (
        .aclk(aclk), .aresetn(aresetn),
        .cmd_valid(cmd_valid), .cmd_ready(cmd_ready), .cmd_write(cmd_write),
        .cmd_addr(cmd_addr), .cmd_wdata(cmd_wdata),
        .rsp_valid(rsp_valid), .rsp_ready(rsp_ready), .rsp_write(rsp_write),
        .rsp_rdata(rsp_rdata), .rsp_resp(rsp_resp), .rsp_timeout(rsp_timeout),
        .AW_VALID(AW_VALID), .AW_READY(AW_READY), .AW_ADDR(AW_ADDR),
        .W_VALID(W_VALID), .W_READY(W_READY), .W_DATA(W_DATA),
        .B_VALID(B_VALID), .B_READY(B_READY), .B_RESP(B_RESP),
        .AR_VALID(AR_VALID), .AR_READY(AR_READY), .AR_ADDR(AR_ADDR),
        .R_VALID(R_VALID), .R_READY(R_READY), .R_DATA(R_DATA), .R_RESP(R_RESP)
    );

    initial aclk = 1'b0;
    always #5 aclk = ~aclk;

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1);
    end

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    task automatic tick();
        @(posedge aclk);
        #1;
    endtask

    task automatic run_txn(input vec_t v);
        int   cyc;
        int   rdy_cnt;
        int   n_hs;
        logic aw_done, w_done, aw_hs, w_hs, rv, rdy;

        cyc = 0;
        while (!cmd_ready && cyc < 50) begin
            tick();
            cyc++;
        end
        chk("cmd_ready_idle", cmd_ready, 32'd1);
        chk("aw_valid_pre", AW_VALID, 32'd0);
        chk("ar_valid_pre", AR_VALID, 32'd0);
        cmd_valid = 1'b1;
        cmd_write = v.wr;
        cmd_addr  = v.addr;
        cmd_wdata = v.wdata;
        tick();
        cmd_valid = 1'b0;
        chk("cmd_ready_busy", cmd_ready, 32'd0);

        if (v.wr) begin
            chk("aw_valid_rise", AW_VALID, 32'd1);
            chk("w_valid_rise", W_VALID, 32'd1);
            chk("aw_addr", AW_ADDR, v.addr);
            chk("w_data", W_DATA, v.wdata);
            aw_done = 1'b0;
            w_done  = 1'b0;
            cyc     = 0;
            while (!(aw_done && w_done) && cyc < 50) begin
                AW_READY = !aw_done && (cyc >= v.a_dly);
                W_READY  = !w_done && (cyc >= v.w_dly);
                chk("aw_valid_hold", AW_VALID, {31'd0, !aw_done});
                chk("w_valid_hold", W_VALID, {31'd0, !w_done});
                chk("b_ready_early", B_READY, 32'd0);
                aw_hs = AW_VALID && AW_READY;
                w_hs  = W_VALID && W_READY;
                if (w_hs) mem[v.addr[5:2]] = W_DATA;
                tick();
                if (aw_hs) aw_done = 1'b1;
                if (w_hs) w_done = 1'b1;
                cyc++;
            end
            AW_READY = 1'b0;
            W_READY  = 1'b0;
            chk("wr_req_done", {31'd0, aw_done && w_done}, 32'd1);
            chk("aw_valid_drop", AW_VALID, 32'd0);
            chk("w_valid_drop", W_VALID, 32'd0);
        end else begin
            chk("ar_valid_rise", AR_VALID, 32'd1);
            chk("ar_addr", AR_ADDR, v.addr);
            aw_done = 1'b0;
            cyc     = 0;
            while (!aw_done && cyc < 50) begin
                AR_READY = (cyc >= v.a_dly);
                chk("ar_valid_hold", AR_VALID, 32'd1);
                chk("r_ready_early", R_READY, 32'd0);
                aw_hs = AR_VALID && AR_READY;
                tick();
                if (aw_hs) aw_done = 1'b1;
                cyc++;
            end
            AR_READY = 1'b0;
            chk("ar_valid_drop", AR_VALID, 32'd0);
        end

        rdy_cnt = 0;
        n_hs    = 0;
        for (int c = 0; c < 40; c++) begin
            rv = (v.r_dly >= 0) && (c >= v.r_dly);
            if (v.wr) begin
                B_VALID = rv;
                B_RESP  = v.sresp;
                rdy     = B_READY;
            end else begin
                R_VALID = rv;
                R_RESP  = v.sresp;
                R_DATA  = mem[v.addr[5:2]];
                rdy     = R_READY;
            end
            if (!rdy) break;
            rdy_cnt++;
            tick();
            if (rv) begin
                n_hs = 1;
                break;
            end
        end
        B_VALID = 1'b0;
        R_VALID = 1'b0;
        chk("resp_handshakes", n_hs, v.e_to ? 32'd0 : 32'd1);
        if (v.e_to) chk("ready_cycles_to_timeout", rdy_cnt, 32'd16);
        chk("b_ready_off", B_READY, 32'd0);
        chk("r_ready_off", R_READY, 32'd0);

        chk("rsp_valid", rsp_valid, 32'd1);
        for (int h = 0; h <= v.hold; h++) begin
            rsp_ready = (h == v.hold);
            chk("rsp_write", rsp_write, {31'd0, v.wr});
            chk("rsp_resp", rsp_resp, {30'd0, v.e_resp});
            chk("rsp_rdata", rsp_rdata, v.e_rdata);
            chk("rsp_timeout", rsp_timeout, {31'd0, v.e_to});
            if (h > 0) begin
                chk("rsp_valid_held", rsp_valid, 32'd1);
                chk("cmd_ready_in_rsp", cmd_ready, 32'd0);
            end
            tick();
        end
        rsp_ready = 1'b0;
        chk("rsp_valid_clear", rsp_valid, 32'd0);
        chk("cmd_ready_back", cmd_ready, 32'd1);
    endtask

    initial begin
        vec_t rd8;

        aresetn   = 1'b0;
        cmd_valid = 1'b0; cmd_write = 1'b0; cmd_addr = 32'd0; cmd_wdata = 32'd0;
        rsp_ready = 1'b0;
        AW_READY  = 1'b0; W_READY = 1'b0; AR_READY = 1'b0;
        B_VALID   = 1'b0; B_RESP = 2'b00;
        R_VALID   = 1'b0; R_DATA = 32'd0; R_RESP = 2'b00;
        for (int i = 0; i < 16; i++) mem[i] = 32'd0;

        //            wr    addr     wdata          a  w  r   sresp  hold e_resp e_rdata        e_to
        vecs[0] = '{1'b1, 32'h4,  32'h1234_5678, 0, 0, 0,  2'b00, 0, 2'b00, 32'h0,         1'b0};
        vecs[1] = '{1'b0, 32'h4,  32'h0,         0, 0, 0,  2'b00, 0, 2'b00, 32'h1234_5678, 1'b0};
        vecs[2] = '{1'b1, 32'h8,  32'hCAFE_F00D, 3, 0, 1,  2'b00, 0, 2'b00, 32'h0,         1'b0};
        vecs[3] = '{1'b1, 32'hC,  32'hDEAD_BEEF, 0, 3, 0,  2'b00, 0, 2'b00, 32'h0,         1'b0};
        vecs[4] = '{1'b1, 32'h10, 32'hA5A5_A5A5, 2, 2, 2,  2'b10, 0, 2'b10, 32'h0,         1'b0};
        vecs[5] = '{1'b0, 32'h8,  32'h0,         2, 0, 3,  2'b00, 5, 2'b00, 32'hCAFE_F00D, 1'b0};
        vecs[6] = '{1'b0, 32'hC,  32'h0,         1, 0, 0,  2'b11, 0, 2'b11, 32'hDEAD_BEEF, 1'b0};
        vecs[7] = '{1'b0, 32'h10, 32'h0,         0, 0, -1, 2'b00, 0, 2'b11, 32'h0,         1'b1};

        repeat (3) tick();
        chk("rst_cmd_ready", cmd_ready, 32'd0);
        chk("rst_aw_valid", AW_VALID, 32'd0);
        chk("rst_w_valid", W_VALID, 32'd0);
        chk("rst_ar_valid", AR_VALID, 32'd0);
        chk("rst_b_ready", B_READY, 32'd0);
        chk("rst_r_ready", R_READY, 32'd0);
        chk("rst_rsp_valid", rsp_valid, 32'd0);
        chk("rst_aw_addr", AW_ADDR, 32'd0);
        chk("rst_w_data", W_DATA, 32'd0);
        aresetn = 1'b1;
        tick();
        chk("cmd_ready_after_rst", cmd_ready, 32'd1);

        for (int i = 0; i < 8; i++) run_txn(vecs[i]);

        // Reset while AW has completed and W is still pending.
        cmd_valid = 1'b1; cmd_write = 1'b1; cmd_addr = 32'h14; cmd_wdata = 32'h1111_2222;
        tick();
        cmd_valid = 1'b0;
        AW_READY  = 1'b1;
        tick();
        AW_READY  = 1'b0;
        chk("abort_aw_done", AW_VALID, 32'd0);
        chk("abort_w_pending", W_VALID, 32'd1);
        aresetn = 1'b0;
        tick();
        aresetn = 1'b1;
        chk("abort_w_valid", W_VALID, 32'd0);
        chk("abort_aw_valid", AW_VALID, 32'd0);
        chk("abort_ar_valid", AR_VALID, 32'd0);
        chk("abort_b_ready", B_READY, 32'd0);
        chk("abort_rsp_valid", rsp_valid, 32'd0);
        chk("abort_cmd_ready", cmd_ready, 32'd0);
        chk("abort_aw_addr", AW_ADDR, 32'd0);
        chk("abort_w_data", W_DATA, 32'd0);
        tick();
        chk("abort_idle_cmd_ready", cmd_ready, 32'd1);
        chk("abort_no_rsp", rsp_valid, 32'd0);
        chk("abort_w_still_low", W_VALID, 32'd0);

        rd8 = '{1'b0, 32'h8, 32'h0, 0, 0, 0, 2'b00, 0, 2'b00, 32'hCAFE_F00D, 1'b0};
        run_txn(rd8);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
